// File: rtl/vcpu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : vcpu_exec
//  Purpose  : Thumb-16 data-processing execution unit. Executes the shift,
//             add/sub, imm8, ALU and hi-register groups against a 16-entry
//             register file. Supports IT blocks with per-instruction condition
//             checks, an iterative shift-and-add multiplier and an
//             undefined-instruction pulse.
//  Ports    : sck, rst        - clock (rising edge), synchronous active-high reset
//             cmd_valid, cmd  - instruction handshake input (Thumb-16 encoding)
//             cmd_ready       - instruction accepted when cmd_valid && cmd_ready
//             nzcv            - condition flags {N,Z,C,V}
//             in_it_block     - ITSTATE[3:0] != 0
//             busy            - multiply in progress
//             undef           - one-cycle pulse after an undefined instruction
//             dbg_sel/dbg_data- combinational register-file read port
//  Revision : 1.0 - initial release
// ============================================================================
module vcpu_exec #(
   parameter int XLEN     = 32,
   parameter int MUL_BITS = 8
) (
   input  logic            sck,
   input  logic            rst,
   input  logic            cmd_valid,
   input  logic [15:0]     cmd,
   output logic            cmd_ready,
   output logic [3:0]      nzcv,
   output logic            in_it_block,
   output logic            busy,
   output logic            undef,
   input  logic [3:0]      dbg_sel,
   output logic [XLEN-1:0] dbg_data
);
   localparam int            STEPS  = XLEN / MUL_BITS;
   localparam int            KW     = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(STEPS - 1);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

   state_t          state_q;
   logic [XLEN-1:0] r_q [16];
   logic [3:0]      nzcv_q, nzcv_d;
   logic [7:0]      it_q, it_d;
   logic            undef_q;
   logic [KW-1:0]   k_q;
   logic [XLEN-1:0] acc_q, mul_a_q, mul_b_q, mul_pp, mul_sum_d;
   logic [3:0]      mul_rd_q;
   logic            mul_fl_q;

   // decode results
   logic            dec_undef, dec_it, dec_mul, wr_en, set_nz, set_c, set_v, flag_any;
   logic            c_new, v_new, in_it, cond_ok, allow, accept;
   logic [3:0]      wr_idx;
   logic [XLEN-1:0] res, opb, lo_d, lo_m, hi_d, hi_m;
   logic [XLEN:0]   sh;
   logic [XLEN+1:0] ad;
   int              amt;

   // op: 0 LSL, 1 LSR, 2 ASR, 3 ROR. Returns {carry, result}.
   function automatic logic [XLEN:0] shift_f(input logic [1:0] op, input logic [XLEN-1:0] v,
                                             input int n, input logic cin);
      logic [XLEN-1:0] r;
      logic [XLEN-1:0] t;
      logic            c;
      int              rot;
      r = v; t = '0; c = cin; rot = 0;
      if (n != 0) begin
         case (op)
            2'd0: begin
               if (n <= XLEN) begin
                  r = v << n;
                  t = v >> (XLEN - n);
                  c = t[0];
               end else begin
                  r = '0;
                  c = 1'b0;
               end
            end
            2'd1: begin
               if (n <= XLEN) begin
                  r = v >> n;
                  t = v >> (n - 1);
                  c = t[0];
               end else begin
                  r = '0;
                  c = 1'b0;
               end
            end
            2'd2: begin
               if (n < XLEN) begin
                  r = $signed(v) >>> n;
                  t = v >> (n - 1);
                  c = t[0];
               end else begin
                  r = {XLEN{v[XLEN-1]}};
                  c = v[XLEN-1];
               end
            end
            default: begin
               rot = n % XLEN;
               r   = (v >> rot) | (v << (XLEN - rot));
               c   = r[XLEN-1];
            end
         endcase
      end
      return {c, r};
   endfunction

   // Returns {overflow, carry, sum}. Subtraction is a + ~b + 1 so carry = NOT borrow.
   function automatic logic [XLEN+1:0] add_f(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                             input logic cin);
      logic [XLEN:0] s;
      logic          ov;
      s  = {1'b0, a} + {1'b0, b} + {{XLEN{1'b0}}, cin};
      ov = (a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
      return {ov, s};
   endfunction

   function automatic logic cond_f(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cc)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return c;
         4'h3: return !c;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return c && !z;
         4'h9: return !c || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   assign busy        = (state_q == S_MUL);
   assign cmd_ready   = !rst && !busy;
   assign accept      = cmd_valid && cmd_ready;
   assign nzcv        = nzcv_q;
   assign undef       = undef_q;
   assign in_it       = (it_q[3:0] != 4'h0);
   assign in_it_block = in_it;
   assign dbg_data    = r_q[dbg_sel];
   assign cond_ok     = !in_it || cond_f(it_q[7:4], nzcv_q);
   // Inside an IT block only the compare/test forms may touch the flags.
   assign allow       = !in_it || flag_any;
   assign it_d        = !in_it ? 8'h00 :
                        (it_q[2:0] == 3'b000) ? 8'h00 : {it_q[7:5], it_q[3:0], 1'b0};
   assign nzcv_d      = {(set_nz && allow) ? res[XLEN-1] : nzcv_q[3],
                         (set_nz && allow) ? (res == '0) : nzcv_q[2],
                         (set_c && allow)  ? c_new      : nzcv_q[1],
                         (set_v && allow)  ? v_new      : nzcv_q[0]};

   always_comb begin
      dec_undef = 1'b0; dec_it = 1'b0; dec_mul = 1'b0;
      wr_en = 1'b0; wr_idx = {1'b0, cmd[2:0]}; res = '0;
      set_nz = 1'b0; set_c = 1'b0; set_v = 1'b0; flag_any = 1'b0;
      c_new = nzcv_q[1]; v_new = nzcv_q[0];
      sh = '0; ad = '0; opb = '0; amt = 0;
      lo_d = r_q[{1'b0, cmd[2:0]}];
      lo_m = r_q[{1'b0, cmd[5:3]}];
      hi_d = r_q[{cmd[7], cmd[2:0]}];
      hi_m = r_q[cmd[6:3]];
      casez (cmd[15:8])
         8'b0001_1???: begin
            opb = cmd[10] ? {{(XLEN-3){1'b0}}, cmd[8:6]} : r_q[{1'b0, cmd[8:6]}];
            ad  = cmd[9] ? add_f(lo_m, ~opb, 1'b1) : add_f(lo_m, opb, 1'b0);
            res = ad[XLEN-1:0]; c_new = ad[XLEN]; v_new = ad[XLEN+1];
            wr_en = 1'b1; set_nz = 1'b1; set_c = 1'b1; set_v = 1'b1;
         end
         8'b000?_????: begin
            // LSR/ASR #0 encode a full-width shift
            amt = (cmd[10:6] == 5'd0 && cmd[12:11] != 2'b00) ? XLEN : int'(cmd[10:6]);
            sh  = shift_f(cmd[12:11], lo_m, amt, nzcv_q[1]);
            res = sh[XLEN-1:0]; c_new = sh[XLEN];
            wr_en = 1'b1; set_nz = 1'b1; set_c = 1'b1;
            if (cmd[12:6] == 7'd0 && in_it) dec_undef = 1'b1;
         end
         8'b001?_????: begin
            opb    = {{(XLEN-8){1'b0}}, cmd[7:0]};
            wr_idx = {1'b0, cmd[10:8]};
            set_nz = 1'b1;
            case (cmd[12:11])
               2'b00:   begin res = opb; wr_en = 1'b1; end
               2'b01:   ad = add_f(r_q[wr_idx], ~opb, 1'b1);
               2'b10:   ad = add_f(r_q[wr_idx], opb, 1'b0);
               default: ad = add_f(r_q[wr_idx], ~opb, 1'b1);
            endcase
            if (cmd[12:11] != 2'b00) begin
               res = ad[XLEN-1:0]; c_new = ad[XLEN]; v_new = ad[XLEN+1];
               set_c = 1'b1; set_v = 1'b1;
               wr_en = (cmd[12:11] != 2'b01);
               flag_any = (cmd[12:11] == 2'b01);
            end
         end
         8'b0100_00??: begin
            wr_en = 1'b1; set_nz = 1'b1;
            case (cmd[9:6])
               4'h0: res = lo_d & lo_m;
               4'h1: res = lo_d ^ lo_m;
               4'h2, 4'h3, 4'h4, 4'h7: begin
                  sh = shift_f((cmd[9:6] == 4'h7) ? 2'd3 : cmd[7:6] - 2'd2, lo_d,
                               int'(lo_m[7:0]), nzcv_q[1]);
                  res = sh[XLEN-1:0]; c_new = sh[XLEN]; set_c = 1'b1;
               end
               4'h8: begin res = lo_d & lo_m; wr_en = 1'b0; flag_any = 1'b1; end
               4'hC: res = lo_d | lo_m;
               4'hD: begin dec_mul = 1'b1; wr_en = 1'b0; set_nz = 1'b0; end
               4'hE: res = lo_d & ~lo_m;
               4'hF: res = ~lo_m;
               default: begin
                  case (cmd[9:6])
                     4'h5:    ad = add_f(lo_d, lo_m, nzcv_q[1]);
                     4'h6:    ad = add_f(lo_d, ~lo_m, nzcv_q[1]);
                     4'h9:    ad = add_f('0, ~lo_m, 1'b1);
                     4'hA:    ad = add_f(lo_d, ~lo_m, 1'b1);
                     default: ad = add_f(lo_d, lo_m, 1'b0);
                  endcase
                  res = ad[XLEN-1:0]; c_new = ad[XLEN]; v_new = ad[XLEN+1];
                  set_c = 1'b1; set_v = 1'b1;
                  if (cmd[9:6] == 4'hA || cmd[9:6] == 4'hB) begin
                     wr_en = 1'b0; flag_any = 1'b1;
                  end
               end
            endcase
         end
         8'b0100_01??: begin
            wr_idx = {cmd[7], cmd[2:0]};
            case (cmd[9:8])
               2'b00: begin res = hi_d + hi_m; wr_en = 1'b1; end
               2'b01: begin
                  ad  = add_f(hi_d, ~hi_m, 1'b1);
                  res = ad[XLEN-1:0]; c_new = ad[XLEN]; v_new = ad[XLEN+1];
                  set_nz = 1'b1; set_c = 1'b1; set_v = 1'b1; flag_any = 1'b1;
                  if (!cmd[7] && !cmd[6]) dec_undef = 1'b1;
               end
               2'b10: begin res = hi_m; wr_en = 1'b1; end
               default: dec_undef = 1'b1;
            endcase
         end
         8'b1011_1111: begin
            dec_it = 1'b1;
            if (cmd[3:0] == 4'h0 || in_it || cmd[7:4] == 4'hF ||
                (cmd[7:4] == 4'hE && cmd[3:0] != 4'b1000))
               dec_undef = 1'b1;
         end
         default: dec_undef = 1'b1;
      endcase
   end

   // Multiplier: MUL_BITS conditional adds of the shifted multiplicand per cycle.
   always_comb begin
      mul_pp = '0;
      for (int j = 0; j < MUL_BITS; j++) begin
         if (mul_b_q[j]) mul_pp = mul_pp + (mul_a_q << j);
      end
      mul_sum_d = acc_q + mul_pp;
   end

   always_ff @(posedge sck) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) r_q[i] <= '0;
         nzcv_q   <= '0;
         it_q     <= '0;
         undef_q  <= 1'b0;
         state_q  <= S_IDLE;
         k_q      <= '0;
         acc_q    <= '0;
         mul_a_q  <= '0;
         mul_b_q  <= '0;
         mul_rd_q <= '0;
         mul_fl_q <= 1'b0;
      end else begin
         undef_q <= 1'b0;
         case (state_q)
            S_MUL: begin
               acc_q   <= mul_sum_d;
               mul_a_q <= mul_a_q << MUL_BITS;
               mul_b_q <= mul_b_q >> MUL_BITS;
               k_q     <= k_q + KW'(1);
               if (k_q == K_LAST) begin
                  r_q[mul_rd_q] <= mul_sum_d;
                  if (mul_fl_q) nzcv_q[3:2] <= {mul_sum_d[XLEN-1], mul_sum_d == '0};
                  state_q <= S_IDLE;
               end
            end
            default: begin
               if (accept) begin
                  if (dec_undef) begin
                     undef_q <= 1'b1;
                  end else if (dec_it) begin
                     it_q <= cmd[7:0];
                  end else begin
                     it_q <= it_d;
                     if (cond_ok) begin
                        if (dec_mul) begin
                           state_q  <= S_MUL;
                           k_q      <= '0;
                           acc_q    <= '0;
                           mul_a_q  <= lo_d;
                           mul_b_q  <= lo_m;
                           mul_rd_q <= {1'b0, cmd[2:0]};
                           mul_fl_q <= !in_it;
                        end else begin
                           if (wr_en) r_q[wr_idx] <= res;
                           nzcv_q <= nzcv_d;
                        end
                     end
                  end
               end
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_vcpu_exec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vcpu_exec
//  Purpose  : Self-checking bench for vcpu_exec (XLEN=32, MUL_BITS=8). A table
//             of instructions with expected register/flag/IT/undef results,
//             followed by hand sequences for multiply timing, back-to-back
//             accepts and reset during a multiply.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vcpu_exec;
   logic        sck = 1'b0;
   logic        rst, cmd_valid, cmd_ready, in_it_block, busy, undef;
   logic [15:0] cmd;
   logic [3:0]  nzcv, dbg_sel;
   logic [31:0] dbg_data;

   int n_chk  = 0;
   int n_fail = 0;

   vcpu_exec #(.XLEN(32), .MUL_BITS(8)) dut (
      .sck(sck), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
      .nzcv(nzcv), .in_it_block(in_it_block), .busy(busy), .undef(undef),
      .dbg_sel(dbg_sel), .dbg_data(dbg_data)
   );

   always #5 sck = ~sck;

   typedef struct packed {
      logic [15:0] cmd;
      logic [3:0]  sel;
      logic [31:0] val;
      logic [3:0]  fl;
      logic        it;
      logic        ud;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [15:0] c, input logic [3:0] s, input logic [31:0] v,
                      input logic [3:0] f, input logic it, input logic ud);
      vec_t e;
      e = '{cmd: c, sel: s, val: v, fl: f, it: it, ud: ud};
      tbl.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic rd(input logic [3:0] s, output logic [31:0] v);
      dbg_sel = s;
      #1;
      v = dbg_data;
   endtask

   logic [31:0] rv;
   int          cnt;

   initial begin
      #100000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd = 16'h0; dbg_sel = 4'd0;
      //       cmd      sel  value          nzcv     it  undef
      add(16'h2101, 4'd1, 32'h00000001, 4'b0000, 0, 0); // MOVS r1,#1
      add(16'h07C9, 4'd1, 32'h80000000, 4'b1000, 0, 0); // LSLS r1,r1,#31
      add(16'h3901, 4'd1, 32'h7FFFFFFF, 4'b0011, 0, 0); // SUBS r1,#1
      add(16'h1C48, 4'd0, 32'h80000000, 4'b1001, 0, 0); // ADDS r0,r1,#1
      add(16'h2205, 4'd2, 32'h00000005, 4'b0001, 0, 0); // MOVS r2,#5
      add(16'h2A05, 4'd2, 32'h00000005, 4'b0110, 0, 0); // CMP r2,#5
      add(16'h1F93, 4'd3, 32'hFFFFFFFF, 4'b1000, 0, 0); // SUBS r3,r2,#6
      add(16'hDE00, 4'd3, 32'hFFFFFFFF, 4'b1000, 0, 1); // undefined
      add(16'h4508, 4'd0, 32'h80000000, 4'b1000, 0, 1); // hi CMP low/low
      add(16'h4680, 4'd8, 32'h80000000, 4'b1000, 0, 0); // MOV r8,r0
      add(16'h44C0, 4'd8, 32'h00000000, 4'b1000, 0, 0); // ADD r8,r8
      add(16'h4542, 4'd2, 32'h00000005, 4'b0010, 0, 0); // CMP r2,r8
      add(16'h2401, 4'd4, 32'h00000001, 4'b0010, 0, 0); // MOVS r4,#1
      add(16'h4320, 4'd0, 32'h80000001, 4'b1010, 0, 0); // ORRS r0,r4
      add(16'h2121, 4'd1, 32'h00000021, 4'b0010, 0, 0); // MOVS r1,#33
      add(16'h4088, 4'd0, 32'h00000000, 4'b0100, 0, 0); // LSLS r0,r1 (33)
      add(16'h2501, 4'd5, 32'h00000001, 4'b0000, 0, 0); // MOVS r5,#1
      add(16'h41E5, 4'd5, 32'h80000000, 4'b1010, 0, 0); // RORS r5,r4
      add(16'h4325, 4'd5, 32'h80000001, 4'b1010, 0, 0); // ORRS r5,r4
      add(16'h2120, 4'd1, 32'h00000020, 4'b0010, 0, 0); // MOVS r1,#32
      add(16'h40CD, 4'd5, 32'h00000000, 4'b0110, 0, 0); // LSRS r5,r1 (32)
      add(16'h101E, 4'd6, 32'hFFFFFFFF, 4'b1010, 0, 0); // ASRS r6,r3,#32
      add(16'h41A6, 4'd6, 32'hFFFFFFFE, 4'b1010, 0, 0); // SBCS r6,r4
      add(16'h4267, 4'd7, 32'hFFFFFFFF, 4'b1000, 0, 0); // RSBS r7,r4
      add(16'h43FF, 4'd7, 32'h00000000, 4'b0100, 0, 0); // MVNS r7,r7
      add(16'hBF0C, 4'd0, 32'h00000000, 4'b0100, 1, 0); // ITE EQ
      add(16'h2001, 4'd0, 32'h00000001, 4'b0100, 1, 0); // MOVS r0,#1 (EQ)
      add(16'h2101, 4'd1, 32'h00000020, 4'b0100, 0, 0); // MOVS r1,#1 (NE fails)
      add(16'hBF08, 4'd0, 32'h00000001, 4'b0100, 1, 0); // IT EQ
      add(16'hBF08, 4'd0, 32'h00000001, 4'b0100, 1, 1); // IT inside IT
      add(16'h3001, 4'd0, 32'h00000002, 4'b0100, 0, 0); // ADDS r0,#1 in IT
      add(16'hBFF8, 4'd0, 32'h00000002, 4'b0100, 0, 1); // IT firstcond 1111
      add(16'hBF18, 4'd0, 32'h00000002, 4'b0100, 1, 0); // IT NE
      add(16'h3001, 4'd0, 32'h00000002, 4'b0100, 0, 0); // fails NE
      add(16'hBF08, 4'd0, 32'h00000002, 4'b0100, 1, 0); // IT EQ
      add(16'h0000, 4'd0, 32'h00000002, 4'b0100, 1, 1); // LSL #0 inside IT
      add(16'h2A05, 4'd2, 32'h00000005, 4'b0110, 0, 0); // CMP in IT sets flags
      add(16'hBFE4, 4'd2, 32'h00000005, 4'b0110, 0, 1); // IT AL bad mask
      add(16'h2001, 4'd0, 32'h00000001, 4'b0010, 0, 0); // MOVS r0,#1
      add(16'h0400, 4'd0, 32'h00010000, 4'b0000, 0, 0); // LSLS r0,r0,#16
      add(16'h3001, 4'd0, 32'h00010001, 4'b0000, 0, 0); // ADDS r0,#1
      add(16'h2101, 4'd1, 32'h00000001, 4'b0000, 0, 0); // MOVS r1,#1
      add(16'h0409, 4'd1, 32'h00010000, 4'b0000, 0, 0); // LSLS r1,r1,#16
      add(16'h3101, 4'd1, 32'h00010001, 4'b0000, 0, 0); // ADDS r1,#1
      add(16'h2A05, 4'd2, 32'h00000005, 4'b0110, 0, 0); // CMP r2,#5

      // reset state
      repeat (2) @(negedge sck);
      chk("rst ready", cmd_ready, 0);
      chk("rst busy", busy, 0);
      chk("rst undef", undef, 0);
      chk("rst nzcv", nzcv, 0);
      chk("rst it", in_it_block, 0);
      rd(4'd0, rv); chk("rst r0", rv, 0);
      rst = 1'b0;
      #1 chk("ready after rst", cmd_ready, 1);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge sck);
         cmd = tbl[i].cmd; cmd_valid = 1'b1;
         @(negedge sck);
         cmd_valid = 1'b0;
         chk($sformatf("v%0d nzcv", i), nzcv, tbl[i].fl);
         chk($sformatf("v%0d it", i), in_it_block, tbl[i].it);
         chk($sformatf("v%0d undef", i), undef, tbl[i].ud);
         rd(tbl[i].sel, rv);
         chk($sformatf("v%0d reg", i), rv, tbl[i].val);
      end

      // MULS r0,r1 with a following MOVS r2,#7 held valid through the multiply
      @(negedge sck);
      cmd = 16'h4348; cmd_valid = 1'b1;
      @(negedge sck);
      cmd = 16'h2207;
      cnt = 0;
      while (busy && cnt < 20) begin
         chk("mul ready low", cmd_ready, 0);
         cnt++;
         @(negedge sck);
      end
      chk("mul busy cycles", cnt, 4);
      chk("mul ready back", cmd_ready, 1);
      chk("mul nzcv", nzcv, 4'b0010);
      rd(4'd0, rv); chk("mul r0", rv, 32'h00020001);
      rd(4'd2, rv); chk("held cmd not early", rv, 32'h5);
      @(negedge sck);
      cmd_valid = 1'b0;
      rd(4'd2, rv); chk("held cmd after mul", rv, 32'h7);

      // back-to-back accepts: second sees first's result
      @(negedge sck);
      cmd = 16'h2309; cmd_valid = 1'b1;
      @(negedge sck);
      cmd = 16'h3301;
      @(negedge sck);
      cmd_valid = 1'b0;
      rd(4'd3, rv); chk("b2b r3", rv, 32'hA);

      // reset during multiply cycle 2
      @(negedge sck);
      cmd = 16'h4348; cmd_valid = 1'b1;
      @(negedge sck);
      cmd_valid = 1'b0;
      chk("mul2 busy", busy, 1);
      @(negedge sck);
      rst = 1'b1;
      @(negedge sck);
      chk("abort busy", busy, 0);
      chk("abort ready", cmd_ready, 0);
      chk("abort nzcv", nzcv, 0);
      chk("abort undef", undef, 0);
      chk("abort it", in_it_block, 0);
      rd(4'd0, rv); chk("abort r0", rv, 0);
      rst = 1'b0;
      #1 chk("abort ready after", cmd_ready, 1);
      repeat (6) @(negedge sck);
      chk("abort busy later", busy, 0);
      rd(4'd0, rv); chk("abort r0 later", rv, 0);
      rd(4'd1, rv); chk("abort r1 later", rv, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/vcpu_exec.md
# vcpu_exec

Parametrised Thumb-16 data-processing execution unit, the successor to `vcpu`. It executes shift, add/sub, immediate, ALU and hi-register instruction groups on a 16-entry register file, and adds the following:
- valid/ready command handshake;
- synchronous reset;
- a real IT instruction with per-instruction condition evaluation;
- an iterative low-power multiplier;
- an undefined-instruction report.

It sits between the fetch/decode front end and the register-file debug port.

## Interface
- `XLEN`, 32: register and datapath width (≥ 8).
- `MUL_BITS`, 8: multiplier bits retired per cycle. Must divide `XLEN`.
- `sck` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: `cmd` holds an instruction.
- `cmd` in 16: Thumb-16 encoding.
- `cmd_ready` out 1: unit accepts `cmd` this cycle.
- `nzcv` out 4: flags {N,Z,C,V}.
- `in_it_block` out 1: ITSTATE[3:0] != 0.
- `busy` out 1: multiply in progress.
- `undef` out 1: one-cycle pulse, previous accepted `cmd` undefined.
- `dbg_sel` in 4: register-file read select.
- `dbg_data` out `XLEN`: r[`dbg_sel`], combinational.

## Operation
- **Accept rule:** accept = `cmd_valid` && `cmd_ready`. `cmd_ready` = !`rst` && !`busy`.
- **Decode classes** (cmd[15:8]):
  - 000x_xxxx: LSL/LSR/ASR by imm5. LSR/ASR imm5=0 means shift by `XLEN`.
  - 0001_1xxx: ADD/SUB reg/imm3.
  - 001x_xxxx: MOV/CMP/ADD/SUB imm8, zero-extended to `XLEN`.
  - 0100_00xx: 16 ALU ops (AND EOR LSL LSR ASR ADC SBC ROR TST RSB CMP CMN ORR MUL BIC MVN).
  - 0100_01xx: hi-register ADD/CMP/MOV. Mode 11 is undef.
  - 1011_1111 with cmd[3:0] != 0: IT firstcond=cmd[7:4], mask=cmd[3:0].
  - All else is undef.
- **Undefined instructions:** no register, flag or ITSTATE change; `undef`=1 the next cycle. Undef cases:
  - IT inside an IT block;
  - IT with firstcond=1111, or firstcond=1110 with a mask other than 1000;
  - LSL #0 low-register MOV (T2) inside an IT block;
  - hi-register CMP with both registers below r8.
- **Arithmetic:**
  - Full `XLEN`-bit two's complement.
  - ADD: C = carry-out.
  - SUB/CMP/SBC/RSB: C = NOT borrow; A−B computed as A+~B+1, SBC uses A+~B+C.
  - V = operands' signs equal (after inversion) and result sign differs.
  - RSB = 0−Rn.
- **Shift by register** (amount = Rm[7:0]):
  - 0: result unchanged, C unchanged.
  - LSL 1..`XLEN`: C = bit `XLEN`−amt.
  - LSL >`XLEN`: result 0, C=0.
  - LSR/ASR ≥`XLEN`: result 0 or sign-fill, C = msb (LSR >`XLEN` gives C=0).
  - ROR: by amt mod `XLEN`. C = result msb if amt != 0.
- **Flag update:**
  - Outside an IT block, every flag-setting form updates N,Z.
  - C is updated by shifts/arith only; V by arith only.
  - Inside an IT block, only CMP/CMN/TST update flags.
  - Hi-register ADD/MOV never update flags.
  - MOV imm8 and LSL #0 with Rd=r15 do not update flags.
  - r15 is a plain register; a write does not branch.
- **MUL:**
  - Low `XLEN` bits of Rdn×Rm, computed shift-and-add at `MUL_BITS`/cycle over `XLEN`/`MUL_BITS` cycles.
  - N,Z are set from the product (unless inside an IT block); C,V are unchanged.
- **ITSTATE** is an 8-bit register:
  - IT loads {firstcond, mask}.
  - Each accepted non-IT instruction executes only if the condition ITSTATE[7:4] passes against the current `nzcv` (ARM cond table, 1110 always). A failed instruction is a no-op.
  - After each accepted non-IT instruction: if ITSTATE[2:0]==0, ITSTATE is cleared; else ITSTATE[4:0] shifts left 1.
  - An undef instruction does not advance ITSTATE.
- **FSM:**
  - IDLE → MUL on accepted MUL that passes its condition.
  - MUL holds a counter k = 0..`XLEN`/`MUL_BITS`−1 and goes back to IDLE after the final step writes Rdn.

## Timing
- **Reset values:** all r[i] = 0, `nzcv` = 0, ITSTATE = 0, `in_it_block` = 0, `busy` = 0, `undef` = 0, FSM = IDLE. `cmd_ready` = 0 while `rst`=1 and 1 in the first cycle after.
- **Single-cycle ops:** register, flag and ITSTATE updates are visible one cycle after accept. Back-to-back accepts are allowed; the second instruction sees the first's results.
- **MUL:**
  - `busy` and !`cmd_ready` from the cycle after accept for `XLEN`/`MUL_BITS` cycles.
  - The result and flags are visible the cycle `busy` falls.
  - ITSTATE advances at accept.
- **Reset mid-multiply:** `rst` aborts the multiply. Rdn stays 0 (reset value) and the FSM returns to IDLE.
- **`dbg_data` read during the cycle a write occurs:** returns the old value.

## Test plan
- **Add overflow:** r1=0x7FFFFFFF, ADDS r0,r1,#1 → r0=0x80000000, nzcv=1001.
- **Compare:** MOVS r2,#5; CMP r2,#5 → nzcv=0110. SUBS r3,r2,#6 → r3=0xFFFFFFFF, nzcv=1000.
- **IT block:** Z=1; ITE EQ (0xBF0C) then MOVS r0,#1; MOVS r1,#1 → r0=1, r1 unchanged, flags unchanged, `in_it_block` falls after the second instruction.
- **Multiply:** `XLEN`=32, `MUL_BITS`=8, r0=0x10001, r1=0x10001, MULS → `busy` high for 4 cycles, r0=0x00020001, N=0, Z=0; `cmd_valid` held high is not accepted until `busy` falls.
- **Shift boundaries:** r0=0x80000001, r1=33, LSLS r0,r1 → r0=0, C=0. Second case: r1=32, LSRS → r0=0, C=1.
- **Undef and reset:** undef 0xDE00 → `undef` pulse, no state change. IT inside an IT block → `undef`. `rst` during MUL cycle 2 → all outputs at reset values next cycle.
